// File: rtl/imem_responder_pkg.sv
// Shared constants, state encoding and address-check helper for the
// instruction-fetch responder.
package imem_responder_pkg;

  localparam int SIZE_WORD           = 32;
  localparam int DEFAULT_LATENCY     = 2;
  localparam int DEFAULT_DEPTH_WORDS = 1024;

  localparam logic [SIZE_WORD-1:0] FAULT_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the byte address is word aligned and inside the store.
  function automatic logic addr_ok(input logic [31:0] addr, input int depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(depth));
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction store: one synchronous write port for program load and an
// asynchronous read port that the responder samples on the accept edge.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [SIZE_WORD-1:0]           wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [SIZE_WORD-1:0]           rdata
);

  logic [SIZE_WORD-1:0] mem [DEPTH_WORDS];

  // Contents survive reset so a program loaded once can be re-run.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: fixed-latency word fetch with fault flagging,
// valid/ready on both channels, flush, and an independent program-load port.
//
// state | meaning
// IDLE  | no request outstanding, ready to accept
// WAIT  | request accepted, latency counter running down
// RESP  | response presented, held until resp_ready
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [SIZE_WORD-1:0] resp_instr,
  output logic                 resp_fault,
  input  logic                 flush,
  input  logic                 load_en,
  input  logic [31:0]          load_addr,
  input  logic [SIZE_WORD-1:0] load_data
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

  state_t               state, state_nxt;
  logic [2:0]           cnt, cnt_nxt;
  logic                 accept;
  logic                 enter_resp;
  logic                 req_ok;
  logic                 load_ok;
  logic [SIZE_WORD-1:0] rd_word;
  logic [SIZE_WORD-1:0] new_instr;
  logic [SIZE_WORD-1:0] cap_instr;
  logic                 cap_fault;

  assign req_ok    = addr_ok(req_addr, DEPTH_WORDS);
  assign load_ok   = load_en && addr_ok(load_addr, DEPTH_WORDS);
  assign new_instr = req_ok ? rd_word : FAULT_INSTR;

  assign req_ready  = !flush && ((state == IDLE) || ((state == RESP) && resp_ready));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (load_ok),
    .waddr (load_addr[AW+1:2]),
    .wdata (load_data),
    .raddr (req_addr[AW+1:2]),
    .rdata (rd_word)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt_nxt    = CNT_LOAD;
            state_nxt  = (LATENCY == 1) ? RESP : WAIT;
            enter_resp = (LATENCY == 1);
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
        RESP: begin
          if (accept) begin
            cnt_nxt    = CNT_LOAD;
            state_nxt  = (LATENCY == 1) ? RESP : WAIT;
            enter_resp = (LATENCY == 1);
          end else if (resp_ready) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      cap_instr  <= FAULT_INSTR;
      cap_fault  <= 1'b0;
      resp_instr <= FAULT_INSTR;
      resp_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_instr <= new_instr;
        cap_fault <= !req_ok;
      end
      // Outputs only move when a response is presented, so they keep their
      // last values while resp_valid is low.
      if (enter_resp) begin
        resp_instr <= accept ? new_instr : cap_instr;
        resp_fault <= accept ? !req_ok : cap_fault;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: expected responses are queued at
// accept and compared (data, fault, latency) when the DUT hands them over.
module tb_imem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_instr;
  logic        resp_fault;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  exp_t        exp_q[$];
  logic [31:0] model [int];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_fault (resp_fault),
    .flush      (flush),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t expect_for(input logic [31:0] a, input int c);
    exp_t e;
    e.acc_cyc = c;
    if (a[1:0] != 2'b00 || a[31:2] >= DEPTH) begin
      e.instr = 32'h0;
      e.fault = 1'b1;
    end else begin
      e.instr = model.exists(int'(a[31:2])) ? model[int'(a[31:2])] : 32'h0;
      e.fault = 1'b0;
    end
    return e;
  endfunction

  // Response monitor: freshness drives the latency check, handshake pops.
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid <= 1'b0;
      prev_hs    <= 1'b0;
    end else begin
      if (resp_valid && (!prev_valid || prev_hs)) begin
        if (exp_q.size() == 0) check("spurious_resp", 32'd1, 32'd0);
        else check("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(LAT));
      end
      if (resp_valid && resp_ready && !flush && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("instr", resp_instr, e.instr);
        check("fault", {31'd0, resp_fault}, {31'd0, e.fault});
      end
      prev_valid <= resp_valid;
      prev_hs    <= resp_valid && resp_ready && !flush;
    end
  end

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    if (a[1:0] == 2'b00 && a[31:2] < DEPTH) model[int'(a[31:2])] = d;
  endtask

  task automatic fetch(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1; req_addr = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(expect_for(a, cyc));
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, {31'd0, resp_valid}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] addrs [3];
    logic        ok;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;

    #12;
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_instr", resp_instr, 32'd0);
    check("rst_fault", {31'd0, resp_fault}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Single fetch
    resp_ready = 1'b1;
    load_word(32'h0, 32'h0000_0013);
    fetch(32'h0);
    drain();

    // Back-to-back fetches with req_valid held
    load_word(32'h0, 32'hA);
    load_word(32'h4, 32'hB);
    load_word(32'h8, 32'hC);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr = addrs[k];
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("b2b_timeout", 32'd0, 32'd1);
      if (k > 0) check("b2b_accept_in_resp", {31'd0, resp_valid}, 32'd1);
      @(posedge clk); #1;
      exp_q.push_back(expect_for(addrs[k], cyc));
    end
    req_valid = 1'b0;
    drain();

    // Faults: misaligned and out of range
    fetch(32'h2);
    drain();
    fetch(32'h1000);
    drain();

    // Read-before-write on the accept edge, then ignored bad loads
    load_word(32'h10, 32'h111);
    req_valid = 1'b1; req_addr = 32'h10;
    load_en = 1'b1; load_addr = 32'h10; load_data = 32'h222;
    @(negedge clk);
    check("rbw_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(expect_for(32'h10, cyc));
    model[4] = 32'h222;
    req_valid = 1'b0; load_en = 1'b0;
    drain();
    load_word(32'h11, 32'hDEAD);
    load_word(32'h1010, 32'hBEEF);
    fetch(32'h10);
    drain();

    // Response held with resp_ready low
    resp_ready = 1'b0;
    fetch(32'h4);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_instr", resp_instr, 32'hB);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_release_valid", {31'd0, resp_valid}, 32'd0);
    check("hold_release_ready", {31'd0, req_ready}, 32'd1);
    check("hold_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Flush while waiting
    fetch(32'h8);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    @(negedge clk);
    check("flush_wait_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    exp_q.delete();
    quiet("flush_wait_quiet", 5);

    // Flush while presenting
    resp_ready = 1'b0;
    fetch(32'h8);
    wait_resp();
    @(posedge clk); #1;
    flush = 1'b1; resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    @(negedge clk);
    check("flush_resp_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    exp_q.delete();
    quiet("flush_resp_quiet", 5);

    // Async reset while waiting; storage retained
    fetch(32'h4);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_instr", resp_instr, 32'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    quiet("arst_quiet", 3);
    fetch(32'h8);
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder side of the instruction-fetch interface; serves word fetch requests from the fetch stage out of an on-chip instruction store.
- Fixed, parameterised response latency; valid/ready handshake on both request and response channels.
- Flags misaligned and out-of-range addresses as faults so fetch can halt.
- Includes a program-load write port used by the testbench/boot loader before or between runs.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit instruction words stored; power of two.
- LATENCY, 2, request-accept to resp_valid delay in cycles; legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address of the instruction.
- resp_valid  out  1  response data valid.
- resp_ready  in  1  fetch stage consumes the response this cycle.
- resp_instr  out  32  instruction word; 32'h0 on fault.
- resp_fault  out  1  request was misaligned or out of range.
- flush  in  1  discard any in-flight or held response (branch/jump redirect).
- load_en  in  1  program-load write strobe.
- load_addr  in  32  byte address for the load write.
- load_data  in  32  word written on load.

Behaviour:
- Reset (rst low, async): state IDLE, resp_valid=0, resp_instr=0, resp_fault=0, latency counter=0. Storage contents are not reset. Reset mid-operation aborts the transaction; no response is produced.
- States: IDLE, WAIT, RESP. One outstanding request at most.
- req_ready = !flush && (state==IDLE || (state==RESP && resp_ready)).
- Accept = req_valid && req_ready. On accept:
  - Capture the fault status and the read word.
  - Load counter with LATENCY-1.
  - LATENCY==1 goes directly to RESP; otherwise enter WAIT.
- WAIT: decrement counter each cycle. When the counter reaches 0, enter RESP on the next edge. resp_valid rises exactly LATENCY edges after the accept edge.
- RESP: resp_valid=1; resp_instr and resp_fault are held stable until the resp_ready handshake.
  - resp_ready without accept -> IDLE.
  - resp_ready with accept -> back-to-back: resp_valid drops next cycle and the new response arrives LATENCY edges later. Sustained throughput is one fetch per LATENCY cycles.
- Fault: req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS -> resp_fault=1, resp_instr=32'h0. Faults observe the same latency and handshake; storage is not accessed.
- Storage read happens at the accept edge (data captured then). A load to the same word on the same edge returns the old data (read-before-write).
- Load: on load_en, write load_data to word load_addr[31:2]. Loads are independent of the fetch FSM and legal in any state. Misaligned or out-of-range load_addr is silently ignored.
- Flush (sync, highest priority): next edge -> IDLE, resp_valid=0, counter=0. A request presented in a flush cycle is not accepted (req_ready=0). resp_ready during flush has no effect.
- resp_valid never asserts without a prior accepted request. resp_instr/resp_fault keep their last values when resp_valid=0.

Decomposition:
- Shared package/defines hold:
  - word size constant (SIZE_WORD)
  - fault instruction value 32'h0
  - FSM state encodings IDLE/WAIT/RESP
  - default LATENCY and DEPTH_WORDS
- One sub-module, imem_array: DEPTH_WORDS x 32 storage with one sync write port (load) and one read port sampled at accept. The FSM, counter, fault decode and output registers live in imem_responder.

Test Plan:
- Load word 0x00000013 at addr 0x0, then request addr 0x0 with LATENCY=2 and resp_ready=1 -> resp_valid rises 2 edges after accept; resp_instr=0x00000013, resp_fault=0.
- Preload 0x0/0x4/0x8 with 0xA, 0xB, 0xC; hold req_valid=1 with addresses stepping and resp_ready=1 -> responses 0xA, 0xB, 0xC in order, one per 2 cycles, req_ready high on each RESP handshake cycle.
- Request addr 0x2, then addr 0x1000 (DEPTH 1024) -> both responses have resp_fault=1, resp_instr=0, same latency as a normal fetch.
- Response for 0x4 held with resp_ready=0 for 5 cycles -> resp_valid and resp_instr stay stable, req_ready=0; then raise resp_ready -> IDLE next cycle.
- Assert flush in WAIT, and separately in RESP -> IDLE next edge, resp_valid=0, no late response; a request in the flush cycle is not accepted.
- Drop rst in WAIT -> resp_valid=0 immediately (async). After release, a fetch of a previously loaded word returns the preloaded value (contents retained).
